// File: rtl/traffic_sequencer.sv
// Traffic-light sequencer for the Norton/Thevenin intersection: internal second
// prescaler, phase timer, per-cycle demand table and flashing night mode.
`timescale 1ns/1ps
module traffic_sequencer #(
    parameter int TICKS_PER_SEC = 10000,
    parameter int SEC_W         = 8,
    parameter int YELLOW_S      = 3,
    parameter int CLEAR_S       = 1,
    parameter int ALLRED_S      = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_general,
    input  logic             SNN,
    input  logic             SNS,
    input  logic             STH,
    output logic [1:0]       Semaforo_NN,
    output logic [1:0]       Semaforo_NS,
    output logic [1:0]       Semaforo_TH,
    output logic [1:0]       Giro_NN_izq,
    output logic [1:0]       Giro_NN_der,
    output logic [1:0]       Giro_TH_izq,
    output logic [1:0]       Semaforo_peaton_N,
    output logic [1:0]       Semaforo_peaton_TH1,
    output logic [1:0]       Semaforo_peaton_TH2,
    output logic [3:0]       phase,
    output logic [SEC_W-1:0] remaining,
    output logic             cycle_start
);

    localparam int                PRE_W   = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] YL = 2'b01;
    localparam logic [1:0] GR = 2'b10;
    localparam logic [1:0] OF = 2'b11;

    typedef enum logic [3:0] {
        P0     = 4'd0,
        P1     = 4'd1,
        P2     = 4'd2,
        P3     = 4'd3,
        P4     = 4'd4,
        P5     = 4'd5,
        P6     = 4'd6,
        P7     = 4'd7,
        P8     = 4'd8,
        P9     = 4'd9,
        P10    = 4'd10,
        P11    = 4'd11,
        PFLASH = 4'd15
    } phase_e;

    typedef enum logic [1:0] {
        TAB_A = 2'd0,
        TAB_B = 2'd1,
        TAB_C = 2'd2,
        TAB_D = 2'd3
    } table_e;

    phase_e             phase_q, phase_d, next_phase;
    table_e             table_q, table_d;
    logic [SEC_W-1:0]   remaining_q, remaining_d;
    logic [PRE_W-1:0]   prescaler_q, prescaler_d;
    logic               flash_yel_q, flash_yel_d;
    logic               cycle_start_q, cycle_start_d;
    logic [17:0]        lamps_q, lamps_d;
    logic [2:0]         sens_meta_q, sens_sync_q;
    logic               tick;

    // Sensor bits are kept as {STH, SNS, SNN}; only a single active sensor selects B/C/D.
    function automatic table_e select_table(input logic [2:0] s);
        table_e t;
        case (s)
            3'b100:  t = TAB_B;
            3'b001:  t = TAB_C;
            3'b010:  t = TAB_D;
            default: t = TAB_A;
        endcase
        return t;
    endfunction

    function automatic logic [SEC_W-1:0] phase_dur(input phase_e p, input table_e t);
        int d;
        case (p)
            P0:                d = ALLRED_S;
            P1:                d = 17;
            P2, P5, P8, P11:   d = YELLOW_S;
            P3, P6, P9:        d = CLEAR_S;
            P4: begin
                case (t)
                    TAB_A:   d = 55;
                    TAB_B:   d = 82;
                    default: d = 27;
                endcase
            end
            P7: begin
                case (t)
                    TAB_A:   d = 27;
                    TAB_D:   d = 54;
                    default: d = 14;
                endcase
            end
            P10: begin
                case (t)
                    TAB_A:   d = 24;
                    TAB_C:   d = 48;
                    default: d = 12;
                endcase
            end
            default:           d = ALLRED_S;
        endcase
        return SEC_W'(d);
    endfunction

    // Packed in port order: NN, NS, TH, GNNizq, GNNder, GTHizq, PN, PTH1, PTH2.
    function automatic logic [17:0] lamp_pattern(input phase_e p, input logic flash_yel);
        logic [17:0] l;
        case (p)
            P0:      l = {RD, RD, RD, RD, RD, RD, RD, RD, RD};
            P1:      l = {RD, RD, RD, RD, GR, GR, RD, GR, RD};
            P2:      l = {RD, RD, RD, RD, RD, GR, RD, GR, GR};
            P3:      l = {RD, RD, YL, RD, RD, RD, RD, GR, GR};
            P4:      l = {RD, RD, GR, RD, RD, RD, RD, GR, GR};
            P5:      l = {RD, RD, YL, RD, RD, RD, RD, GR, GR};
            P6:      l = {RD, YL, RD, RD, RD, RD, GR, RD, RD};
            P7:      l = {RD, GR, RD, RD, RD, RD, GR, RD, RD};
            P8:      l = {RD, YL, RD, RD, RD, RD, GR, RD, RD};
            P9:      l = {YL, RD, RD, RD, RD, RD, GR, RD, RD};
            P10:     l = {GR, RD, RD, GR, GR, RD, GR, RD, RD};
            P11:     l = {YL, RD, RD, RD, GR, RD, GR, GR, RD};
            PFLASH:  l = flash_yel ? {YL, YL, YL, OF, OF, OF, OF, OF, OF}
                                   : {OF, OF, OF, OF, OF, OF, OF, OF, OF};
            default: l = {RD, RD, RD, RD, RD, RD, RD, RD, RD};
        endcase
        return l;
    endfunction

    assign tick       = (prescaler_q == PRE_MAX);
    assign next_phase = (phase_q == P11) ? P1 : phase_e'(phase_q + 4'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sens_meta_q <= '0;
            sens_sync_q <= '0;
        end else begin
            sens_meta_q <= {STH, SNS, SNN};
            sens_sync_q <= sens_meta_q;
        end
    end

    // Flash mode overrides everything; leaving it restarts from a fresh all-red phase.
    always_comb begin
        phase_d       = phase_q;
        table_d       = table_q;
        remaining_d   = remaining_q;
        prescaler_d   = prescaler_q;
        flash_yel_d   = flash_yel_q;
        cycle_start_d = 1'b0;

        if (!enable_general) begin
            remaining_d = '0;
            if (phase_q != PFLASH) begin
                phase_d     = PFLASH;
                prescaler_d = '0;
                flash_yel_d = 1'b1;
            end else begin
                prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
                if (tick) begin
                    flash_yel_d = ~flash_yel_q;
                end
            end
        end else if (phase_q == PFLASH) begin
            phase_d     = P0;
            prescaler_d = '0;
            remaining_d = phase_dur(P0, table_q);
        end else begin
            prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
            if (tick) begin
                if (remaining_q == SEC_W'(1)) begin
                    phase_d     = next_phase;
                    remaining_d = phase_dur(next_phase, table_q);
                    if (next_phase == P1) begin
                        table_d       = select_table(sens_sync_q);
                        cycle_start_d = 1'b1;
                    end
                end else begin
                    remaining_d = remaining_q - SEC_W'(1);
                end
            end
        end

        lamps_d = lamp_pattern(phase_d, flash_yel_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q       <= P0;
            table_q       <= TAB_A;
            remaining_q   <= SEC_W'(ALLRED_S);
            prescaler_q   <= '0;
            flash_yel_q   <= 1'b1;
            cycle_start_q <= 1'b0;
            lamps_q       <= {RD, RD, RD, RD, RD, RD, RD, RD, RD};
        end else begin
            phase_q       <= phase_d;
            table_q       <= table_d;
            remaining_q   <= remaining_d;
            prescaler_q   <= prescaler_d;
            flash_yel_q   <= flash_yel_d;
            cycle_start_q <= cycle_start_d;
            lamps_q       <= lamps_d;
        end
    end

    assign Semaforo_NN         = lamps_q[17:16];
    assign Semaforo_NS         = lamps_q[15:14];
    assign Semaforo_TH         = lamps_q[13:12];
    assign Giro_NN_izq         = lamps_q[11:10];
    assign Giro_NN_der         = lamps_q[9:8];
    assign Giro_TH_izq         = lamps_q[7:6];
    assign Semaforo_peaton_N   = lamps_q[5:4];
    assign Semaforo_peaton_TH1 = lamps_q[3:2];
    assign Semaforo_peaton_TH2 = lamps_q[1:0];
    assign phase               = phase_q;
    assign remaining           = remaining_q;
    assign cycle_start         = cycle_start_q;

endmodule
